// File: rtl/demosaic_frame_ctrl.sv
// rtl/demosaic_frame_ctrl.sv - frame sequencer for the nearest-neighbour Bayer demosaic stage
// Clears the stage, meters source pixels in, pads two lines of zeros and audits the output count.
module demosaic_frame_ctrl #(
  parameter int width  = 320,
  parameter int height = 240,
  parameter int cntW   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_err,
  input  logic [7:0]      src_data,
  input  logic            src_valid,
  output logic            src_ready,
  input  logic            sink_ready,
  output logic            dm_reset,
  output logic [7:0]      dm_data,
  output logic            dm_valid,
  input  logic            dm_oValid,
  input  logic            dm_oDone,
  output logic [cntW-1:0] in_cnt,
  output logic [cntW-1:0] out_cnt
);

  localparam logic [cntW-1:0] src_total = cntW'(width * height);
  localparam logic [cntW-1:0] pad_total = cntW'(width * (height + 2));

  typedef enum logic [2:0] {
    s_idle,
    s_clear,
    s_feed,
    s_flush,
    s_wait,
    s_done
  } state_t;

  state_t          state;
  logic            clr_first;
  logic [1:0]      wait_cnt;
  logic            xfer;
  logic            out_inc;
  logic [cntW-1:0] out_nxt;
  logic [cntW-1:0] in_nxt;

  assign src_ready = (state == s_feed) && sink_ready;
  assign xfer      = src_valid && src_ready;

  // Output beats are counted across the whole busy window and saturate.
  assign out_inc = busy && dm_oValid && (out_cnt != {cntW{1'b1}});
  assign out_nxt = out_inc ? out_cnt + cntW'(1) : out_cnt;
  assign in_nxt  = in_cnt + cntW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= s_idle;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      dm_reset   <= 1'b1;
      dm_valid   <= 1'b0;
      dm_data    <= 8'd0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      clr_first  <= 1'b0;
      wait_cnt   <= 2'd0;
    end else begin
      frame_done <= 1'b0;
      dm_valid   <= 1'b0;
      out_cnt    <= out_nxt;
      case (state)
        s_idle: begin
          dm_reset <= 1'b0;
          if (start) begin
            state     <= s_clear;
            busy      <= 1'b1;
            dm_reset  <= 1'b1;
            frame_err <= 1'b0;
            clr_first <= 1'b1;
            in_cnt    <= '0;
            out_cnt   <= '0;
          end
        end
        s_clear: begin
          in_cnt  <= '0;
          out_cnt <= '0;
          if (clr_first) begin
            clr_first <= 1'b0;
          end else begin
            dm_reset <= 1'b0;
            state    <= s_feed;
          end
        end
        s_feed: begin
          if (xfer) begin
            dm_data  <= src_data;
            dm_valid <= 1'b1;
            in_cnt   <= in_nxt;
            if (in_nxt == src_total) state <= s_flush;
          end
        end
        s_flush: begin
          // Zero padding pushes the last two lines out of the stage's line buffers.
          if (sink_ready) begin
            dm_data  <= 8'd0;
            dm_valid <= 1'b1;
            in_cnt   <= in_nxt;
            if (in_nxt == pad_total) begin
              state    <= s_wait;
              wait_cnt <= 2'd0;
            end
          end
        end
        s_wait: begin
          if (dm_oDone) begin
            state      <= s_done;
            frame_done <= 1'b1;
            frame_err  <= (out_nxt != src_total);
          end else if (wait_cnt == 2'd3) begin
            state      <= s_done;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        s_done: begin
          busy  <= 1'b0;
          state <= s_idle;
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// tb/tb_demosaic_frame_ctrl.sv - randomized self-checking bench for demosaic_frame_ctrl
// A pixel-order model and a lagging demosaic model are compared against the DUT every cycle.
module tb_demosaic_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NTOT = W * (H + 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        src_valid = 1'b0;
  logic        sink_ready = 1'b0;
  logic        dm_oValid = 1'b0;
  logic        dm_oDone = 1'b0;
  logic        busy, frame_done, frame_err, src_ready, dm_reset, dm_valid;
  logic [7:0]  dm_data;
  logic [31:0] in_cnt, out_cnt;

  demosaic_frame_ctrl #(.width(W), .height(H), .cntW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .sink_ready(sink_ready), .dm_reset(dm_reset), .dm_data(dm_data),
    .dm_valid(dm_valid), .dm_oValid(dm_oValid), .dm_oDone(dm_oDone),
    .in_cnt(in_cnt), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pix [NPIX];
  int  src_idx, dmv_cnt, exp_out, rst_cycles, stall_left;
  bit  xfer_pend, o_pend, o_pend_done, exp_busy, tog, st1, st2;
  bit  do_start, spur_start, rst_req, done_seen;
  int  src_mode, sink_mode;
  bit  drop, nodone;
  int  cap_in, cap_out;
  bit  cap_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_busy = 0; dmv_cnt = 0; exp_out = 0; o_pend = 0; o_pend_done = 0;
    src_idx = 0; xfer_pend = 0; rst_cycles = 0;
  endtask

  task automatic step();
    logic [7:0] exp_d;
    @(negedge clk);
    if (xfer_pend) src_idx++;
    if (!reset) begin
      chk("rst_dm_reset", dm_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_dm_valid", dm_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_in_cnt", in_cnt, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_src_ready", src_ready, 0);
    end else begin
      if (dm_valid) begin
        chk("dm_valid_after_sink_low", sink_ready, 1);
        exp_d = (dmv_cnt < NPIX) ? pix[dmv_cnt] : 8'd0;
        chk("dm_data", dm_data, exp_d);
        dmv_cnt++;
      end
      chk("in_cnt", in_cnt, dmv_cnt);
      chk("out_cnt", out_cnt, exp_out);
      chk("busy", busy, exp_busy);
      if (!exp_busy || !sink_ready) chk("src_ready", src_ready, 0);
      if (!exp_busy) begin
        chk("idle_dm_reset", dm_reset, 0);
        chk("idle_dm_valid", dm_valid, 0);
      end
      if (exp_busy && dm_reset) rst_cycles++;
      if (frame_done) begin
        chk("done_expected", exp_busy, 1);
        chk("done_in_cnt", in_cnt, NTOT);
        chk("done_out_cnt", out_cnt, exp_out);
        chk("done_err", frame_err, ((exp_out != NPIX) || nodone) ? 1 : 0);
        chk("done_clear_cycles", rst_cycles, 2);
        cap_in = in_cnt; cap_out = out_cnt; cap_err = frame_err;
        done_seen = 1;
        exp_busy = 0;
      end
    end
    // demosaic model: one-cycle lag, first two lines of input produce no output
    dm_oValid = o_pend;
    dm_oDone  = o_pend_done;
    if (o_pend) exp_out++;
    o_pend      = reset && dm_valid && (dmv_cnt > 2 * W) && !(drop && dmv_cnt == 2 * W + 5);
    o_pend_done = reset && dm_valid && (dmv_cnt == NTOT) && !nodone;
    reset = !rst_req;
    if (!reset) begin
      clear_model();
      dm_oValid = 0; dm_oDone = 0;
    end
    case (sink_mode)
      1: begin
        if (stall_left > 0) begin sink_ready = 0; stall_left--; end
        else if (!st1 && dmv_cnt >= 10) begin st1 = 1; stall_left = 4; sink_ready = 0; end
        else if (!st2 && dmv_cnt >= 38) begin st2 = 1; stall_left = 4; sink_ready = 0; end
        else sink_ready = 1;
      end
      2: sink_ready = ($urandom_range(0, 3) != 0);
      default: sink_ready = 1;
    endcase
    case (src_mode)
      1: begin src_valid = tog && (src_idx < NPIX); tog = !tog; end
      2: src_valid = ($urandom_range(0, 1) == 1) && (src_idx < NPIX);
      default: src_valid = (src_idx < NPIX);
    endcase
    src_data = src_valid ? pix[src_idx] : 8'($urandom);
    start = 0;
    if (do_start && reset) begin
      start = 1; do_start = 0;
      exp_busy = 1; dmv_cnt = 0; exp_out = 0; rst_cycles = 0; src_idx = 0;
    end else if (spur_start) begin
      start = 1; spur_start = 0;
    end
    #1;
    xfer_pend = src_valid && src_ready;
  endtask

  task automatic run_frame(input int sm, input int km, input bit dr, input bit nd, input bit abort);
    bit aborted;
    bit spurred;
    aborted = 0; spurred = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(1, 255));
    src_mode = sm; sink_mode = km; drop = dr; nodone = nd;
    tog = 1; st1 = 0; st2 = 0; stall_left = 0;
    done_seen = 0; do_start = 1;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      step();
      if (!spurred && exp_busy && dmv_cnt == 20) begin spur_start = 1; spurred = 1; end
      if (abort && !aborted && dmv_cnt >= 40) begin
        aborted = 1;
        rst_req = 1;
        repeat (3) step();
        rst_req = 0;
        repeat (20) step();
        chk("abort_no_done", done_seen, 0);
        break;
      end
    end
    if (!abort && !done_seen) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=no_frame_done required=frame_done");
    end
    repeat (3) step();
  endtask

  initial begin
    clear_model();
    rst_req = 1; do_start = 0; spur_start = 0; done_seen = 0;
    src_mode = 0; sink_mode = 0; drop = 0; nodone = 0;
    repeat (3) step();
    rst_req = 0;
    repeat (10) step();

    run_frame(0, 0, 0, 0, 0);
    chk("A_in_cnt", cap_in, 48);
    chk("A_out_cnt", cap_out, 32);
    chk("A_err", cap_err, 0);

    run_frame(1, 0, 0, 0, 0);
    chk("B_in_cnt", cap_in, 48);
    chk("B_err", cap_err, 0);

    run_frame(0, 1, 0, 0, 0);
    chk("C_out_cnt", cap_out, 32);
    chk("C_err", cap_err, 0);

    run_frame(0, 0, 1, 0, 0);
    chk("D_out_cnt", cap_out, 31);
    chk("D_err", cap_err, 1);

    run_frame(0, 0, 0, 1, 0);
    chk("E_out_cnt", cap_out, 32);
    chk("E_err", cap_err, 1);

    run_frame(0, 0, 0, 0, 1);
    run_frame(0, 0, 0, 0, 0);
    chk("F_in_cnt", cap_in, 48);
    chk("F_err", cap_err, 0);

    for (int k = 0; k < 4; k++) begin
      run_frame(2, 2, 0, 0, 0);
      chk("R_err", cap_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
